// File: rtl/fft_pass_sequencer_pkg.sv
// Shared AGU mode codes, transform-size defaults and sequencer state encoding
// for the FFT pass sequencer and its counter.
package fft_pass_sequencer_pkg;

  localparam int AGU_MODE_WIDTH = 3;
  localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_IDLE   = 3'd0;
  localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_BF_RAM = 3'd2;

  localparam int LOG_N        = 8;
  localparam int NO_OF_POINTS = 1 << LOG_N;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_ARM    = 3'd1,
    SEQ_RUN    = 3'd2,
    SEQ_DRAIN  = 3'd3,
    SEQ_FINISH = 3'd4
  } seqState_t;

endpackage

// File: rtl/fft_seq_counter.sv
// Cascaded phase/butterfly/stage counter for one FFT pass. Holds its final
// values once the last butterfly slot has been reached.
module fft_seq_counter #(
  parameter int LOG_N     = 8,
  parameter int BF_CYCLES = 8,
  parameter int STAGE_W   = 3,
  parameter int PHASE_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  output logic [STAGE_W-1:0] stage,
  output logic [LOG_N-2:0]   bfIndex,
  output logic               stageWrap,
  output logic               lastSlot
);
  import fft_pass_sequencer_pkg::*;

  localparam int BF_W = LOG_N - 1;

  logic [PHASE_W-1:0] phase_r;
  logic               phaseLast_s;
  logic               bfLast_s;
  logic               stageLast_s;

  assign phaseLast_s = (phase_r == PHASE_W'(BF_CYCLES - 1));
  assign bfLast_s    = (bfIndex == {BF_W{1'b1}});
  // Exact terminal compare so non-power-of-two stage counts stop correctly.
  assign stageLast_s = (stage == STAGE_W'(LOG_N - 1));
  assign stageWrap   = enable && phaseLast_s && bfLast_s;
  assign lastSlot    = stageWrap && stageLast_s;

  // Advance phase every enabled cycle, carrying into butterfly and stage.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase_r <= '0;
      bfIndex <= '0;
      stage   <= '0;
    end else if (enable && !lastSlot) begin
      if (phaseLast_s) begin
        phase_r <= '0;
        if (bfLast_s) begin
          bfIndex <= '0;
          stage   <= stage + STAGE_W'(1);
        end else begin
          bfIndex <= bfIndex + BF_W'(1);
        end
      end else begin
        phase_r <= phase_r + PHASE_W'(1);
      end
    end
  end

endmodule

// File: rtl/fft_pass_sequencer.sv
// Sequences the butterfly AGU through one in-place FFT/IFFT pass.
// Optional feature macro: FFT_SEQ_IFFT_EN (latch ifft_req into agu_ifft).
module fft_pass_sequencer #(
  parameter int LOG_N        = 8,
  parameter int BF_CYCLES    = 8,
  parameter int DRAIN_CYCLES = 8,
  localparam int STAGE_W = (LOG_N > 1) ? $clog2(LOG_N) : 1,
  localparam int PHASE_W = (BF_CYCLES > 1) ? $clog2(BF_CYCLES) : 1,
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic                                             abort,
  input  logic                                             ifft_req,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             stage_done,
  output logic [STAGE_W-1:0]                               stage,
  output logic [LOG_N-2:0]                                 bf_index,
  output logic                                             agu_reset,
  output logic                                             agu_start,
  output logic [fft_pass_sequencer_pkg::AGU_MODE_WIDTH-1:0] agu_mode,
  output logic                                             agu_oe,
  output logic                                             agu_ifft
);
  import fft_pass_sequencer_pkg::*;

  seqState_t          state_r;
  logic [DRAIN_W-1:0] drainCnt_r;
  logic               startTaken_s;
  logic               abortTaken_s;
  logic               cntClear_s;
  logic               cntEnable_s;
  logic               stageWrap_s;
  logic               lastSlot_s;
  logic               ifftLoad_s;

  assign startTaken_s = (state_r == SEQ_IDLE) && start;
  assign abortTaken_s = abort && ((state_r == SEQ_ARM) || (state_r == SEQ_RUN) ||
                                  (state_r == SEQ_DRAIN));
  assign cntClear_s   = startTaken_s || abortTaken_s;
  assign cntEnable_s  = (state_r == SEQ_RUN) && !abort;

`ifdef FFT_SEQ_IFFT_EN
  assign ifftLoad_s = ifft_req;
`else
  logic unusedIfftReq_s;
  assign unusedIfftReq_s = ifft_req;
  assign ifftLoad_s      = 1'b0;
`endif

  fft_seq_counter #(
    .LOG_N     (LOG_N),
    .BF_CYCLES (BF_CYCLES),
    .STAGE_W   (STAGE_W),
    .PHASE_W   (PHASE_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (cntClear_s),
    .enable    (cntEnable_s),
    .stage     (stage),
    .bfIndex   (bf_index),
    .stageWrap (stageWrap_s),
    .lastSlot  (lastSlot_s)
  );

  // Pass FSM; every output is registered and set for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= SEQ_IDLE;
      drainCnt_r <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stage_done <= 1'b0;
      agu_reset  <= 1'b1;
      agu_start  <= 1'b0;
      agu_mode   <= AGU_MODE_IDLE;
      agu_oe     <= 1'b0;
      agu_ifft   <= 1'b0;
    end else begin
      done       <= 1'b0;
      stage_done <= 1'b0;
      agu_start  <= 1'b0;
      if (abortTaken_s) begin
        state_r   <= SEQ_IDLE;
        busy      <= 1'b0;
        agu_reset <= 1'b1;
        agu_mode  <= AGU_MODE_IDLE;
        agu_oe    <= 1'b0;
      end else begin
        case (state_r)
          SEQ_IDLE: begin
            if (start) begin
              state_r  <= SEQ_ARM;
              busy     <= 1'b1;
              agu_ifft <= ifftLoad_s;
            end
          end
          SEQ_ARM: begin
            state_r   <= SEQ_RUN;
            agu_reset <= 1'b0;
            agu_start <= 1'b1;
            agu_mode  <= AGU_MODE_BF_RAM;
            agu_oe    <= 1'b1;
          end
          SEQ_RUN: begin
            stage_done <= stageWrap_s;
            if (lastSlot_s) begin
              state_r    <= SEQ_DRAIN;
              drainCnt_r <= '0;
            end
          end
          SEQ_DRAIN: begin
            // Bus stays owned in BF_RAM mode until the last writebacks land.
            if (drainCnt_r == DRAIN_W'(DRAIN_CYCLES - 1)) begin
              state_r   <= SEQ_FINISH;
              done      <= 1'b1;
              agu_reset <= 1'b1;
              agu_mode  <= AGU_MODE_IDLE;
              agu_oe    <= 1'b0;
            end else begin
              drainCnt_r <= drainCnt_r + DRAIN_W'(1);
            end
          end
          SEQ_FINISH: begin
            state_r <= SEQ_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r   <= SEQ_IDLE;
            busy      <= 1'b0;
            agu_reset <= 1'b1;
            agu_mode  <= AGU_MODE_IDLE;
            agu_oe    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_pass_sequencer.sv
// Self-checking bench for fft_pass_sequencer at LOG_N=3: a timeline model of
// the pass (offset from the accepted start) checked every cycle, plus pinned cycles.
module tb_fft_pass_sequencer;
  import fft_pass_sequencer_pkg::*;

  localparam int LN      = 3;
  localparam int HALF    = 1 << (LN - 1);
  localparam int BFC     = 8;
  localparam int DRN     = 8;
  localparam int STG_CYC = HALF * BFC;
  localparam int RUNC    = LN * STG_CYC;
  localparam int FIN_D   = 2 + RUNC + DRN;
`ifdef FFT_SEQ_IFFT_EN
  localparam logic IFFT_EN = 1'b1;
`else
  localparam logic IFFT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, abort, ifft_req;
  logic busy, done, stage_done, agu_reset, agu_start, agu_oe, agu_ifft;
  logic [1:0] stage;
  logic [1:0] bf_index;
  logic [AGU_MODE_WIDTH-1:0] agu_mode;

  fft_pass_sequencer #(.LOG_N(LN), .BF_CYCLES(BFC), .DRAIN_CYCLES(DRN)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ifft_req(ifft_req),
    .busy(busy), .done(done), .stage_done(stage_done), .stage(stage),
    .bf_index(bf_index), .agu_reset(agu_reset), .agu_start(agu_start),
    .agu_mode(agu_mode), .agu_oe(agu_oe), .agu_ifft(agu_ifft)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   passT = -1;
  int   holdStage = 0;
  int   holdBf = 0;
  logic ifftHeld = 1'b0;
  bit   modelValid = 1'b0;
  int   doneQ[$];
  int   sdQ[$];
  int   startQ[$];
  logic busyLog[0:1023];
  logic ifftLog[0:1023];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // 0 idle, 1 arm, 2 run, 3 drain, 4 finish
  function automatic int modelPhase(input int c);
    int d;
    if (passT < 0) return 0;
    d = c - passT;
    if (d <= 0 || d > FIN_D) return 0;
    if (d == 1) return 1;
    if (d <= 1 + RUNC) return 2;
    if (d <= 1 + RUNC + DRN) return 3;
    return 4;
  endfunction

  task automatic compareCycle();
    int ph, d, s, eStage, eBf;
    logic eBusy, eDone, eSd, eRst, eSt, eOe;
    logic [AGU_MODE_WIDTH-1:0] eMode;
    ph = modelPhase(cyc);
    d = cyc - passT;
    s = d - 2;
    eBusy = (ph != 0); eDone = (ph == 4); eSd = 1'b0; eRst = 1'b1; eSt = 1'b0;
    eOe = 1'b0; eMode = AGU_MODE_IDLE; eStage = holdStage; eBf = holdBf;
    case (ph)
      1: begin eStage = 0; eBf = 0; end
      2: begin
        eStage = s / STG_CYC; eBf = (s / BFC) % HALF;
        eSd = (s > 0) && (s % STG_CYC == 0); eSt = (s == 0);
        eRst = 1'b0; eOe = 1'b1; eMode = AGU_MODE_BF_RAM;
      end
      3: begin
        eStage = LN - 1; eBf = HALF - 1; eSd = (d == 2 + RUNC);
        eRst = 1'b0; eOe = 1'b1; eMode = AGU_MODE_BF_RAM;
      end
      4: begin eStage = LN - 1; eBf = HALF - 1; end
      default: ;
    endcase
    chk("busy", busy, eBusy);
    chk("done", done, eDone);
    chk("stage_done", stage_done, eSd);
    chk("stage", stage, eStage);
    chk("bf_index", bf_index, eBf);
    chk("agu_reset", agu_reset, eRst);
    chk("agu_start", agu_start, eSt);
    chk("agu_mode", agu_mode, eMode);
    chk("agu_oe", agu_oe, eOe);
    chk("agu_ifft", agu_ifft, ifftHeld);
  endtask

  task automatic advanceModel(input logic st, input logic ab, input logic iq, input logic rs);
    int ph;
    ph = modelPhase(cyc);
    if (rs) begin
      passT = -1; holdStage = 0; holdBf = 0; ifftHeld = 1'b0; modelValid = 1'b1;
    end else if (ph == 0) begin
      if (st) begin
        passT = cyc;
        ifftHeld = IFFT_EN ? iq : 1'b0;
      end
    end else if (ph == 4) begin
      holdStage = LN - 1; holdBf = HALF - 1;
    end else if (ab) begin
      passT = -1; holdStage = 0; holdBf = 0;
    end
  endtask

  task automatic step(input logic st, input logic ab, input logic iq, input logic rs);
    if (modelValid) begin
      if (done === 1'b1) doneQ.push_back(cyc);
      if (stage_done === 1'b1) sdQ.push_back(cyc);
      if (agu_start === 1'b1) startQ.push_back(cyc);
      busyLog[cyc] = busy;
      ifftLog[cyc] = agu_ifft;
      compareCycle();
    end
    start = st; abort = ab; ifft_req = iq; reset = rs;
    advanceModel(st, ab, iq, rs);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idleUntil(input int c);
    while (cyc < c) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; ifft_req = 1'b0;
    #1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_agu_reset", agu_reset, 1'b1);
    chk("reset_agu_mode", agu_mode, AGU_MODE_IDLE);

    // Nominal pass: start at 10, ifft_req dropped mid-pass.
    idleUntil(10);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    while (cyc < 20) step(1'b0, 1'b0, 1'b1, 1'b0);
    idleUntil(120);
    chk("agu_start_count", startQ.size(), 1);
    chk("agu_start_cycle", (startQ.size() > 0) ? startQ[0] : -1, 12);
    chk("stage_done_count", sdQ.size(), 3);
    chk("stage_done_0", (sdQ.size() > 0) ? sdQ[0] : -1, 44);
    chk("stage_done_1", (sdQ.size() > 1) ? sdQ[1] : -1, 76);
    chk("stage_done_2", (sdQ.size() > 2) ? sdQ[2] : -1, 108);
    chk("done_count", doneQ.size(), 1);
    chk("done_cycle", (doneQ.size() > 0) ? doneQ[0] : -1, 116);
    chk("busy_at_116", busyLog[116], 1'b1);
    chk("busy_at_117", busyLog[117], 1'b0);
    chk("ifft_at_finish", ifftLog[116], IFFT_EN);
    doneQ.delete(); sdQ.delete(); startQ.delete();

    // start held high: one pass, then a second ARM right after done.
    idleUntil(130);
    while (cyc <= 237) step(1'b1, 1'b0, 1'b0, 1'b0);
    idleUntil(287);
    chk("abort_point_stage", stage, 2'd1);
    chk("abort_point_bf", bf_index, 2'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_agu_reset", agu_reset, 1'b1);
    chk("abort_agu_oe", agu_oe, 1'b0);
    idleUntil(300);
    chk("held_start_done_count", doneQ.size(), 1);
    chk("held_start_done_cycle", (doneQ.size() > 0) ? doneQ[0] : -1, 236);
    chk("second_arm_busy", busyLog[238], 1'b1);
    doneQ.delete(); sdQ.delete(); startQ.delete();

    // reset asserted during DRAIN.
    idleUntil(310);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idleUntil(410);
    chk("drain_agu_oe", agu_oe, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_stage", stage, 2'd0);
    chk("midreset_bf", bf_index, 2'd0);
    chk("midreset_agu_reset", agu_reset, 1'b1);
    chk("midreset_agu_oe", agu_oe, 1'b0);
    chk("midreset_agu_ifft", agu_ifft, 1'b0);
    idleUntil(430);
    chk("midreset_no_done", doneQ.size(), 0);
    doneQ.delete(); sdQ.delete(); startQ.delete();

    // start and abort together in IDLE: start wins and the pass completes.
    idleUntil(440);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    idleUntil(550);
    chk("start_abort_done_count", doneQ.size(), 1);
    chk("start_abort_done_cycle", (doneQ.size() > 0) ? doneQ[0] : -1, 546);
    chk("start_abort_ifft", ifftLog[546], IFFT_EN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_pass_sequencer.md
# fft_pass_sequencer

Top-level controller that sequences the butterfly address generator through one complete in-place FFT/IFFT pass. On `start` it reinitialises the AGU, issues the single start pulse, holds it in butterfly-RAM mode for exactly LOG_N stages × N/2 butterflies × 8 address cycles, and drains the final writebacks. It then signals `done`. It sits between the system controller and the AGU/RAM datapath, and owns the AGU's `reset`, `c_agu_start`, `c_mode`, `outputEnable` and `controlIFFT` inputs.

## Interface
Parameters:
- `LOG_N`, default 8: log2 of transform size N.
- `BF_CYCLES`, default 8: controlPulse cycles per butterfly. Fixed by the AGU; must be a power of two.
- `DRAIN_CYCLES`, default 8: cycles after the last butterfly slot, used to complete the final r1/r2 writebacks.

Ports:
- `clk` input 1: the AGU controlPulse clock.
- `reset` input 1: reset, synchronous, active-high.
- `start` input 1: request a pass. Sampled only in IDLE.
- `abort` input 1: terminate the pass in progress.
- `ifft_req` input 1: inverse-transform select, latched at `start`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse on normal completion.
- `stage_done` output 1: one-cycle pulse at the end of each stage.
- `stage` output clog2(LOG_N): current stage index.
- `bf_index` output LOG_N-1: butterfly index within the stage.
- `agu_reset` output 1: drives the AGU `reset`.
- `agu_start` output 1: drives the AGU `c_agu_start`.
- `agu_mode` output `AGU_MODE_WIDTH: drives the AGU `c_mode`.
- `agu_oe` output 1: drives the AGU `outputEnable`, i.e. write-address bus ownership.
- `agu_ifft` output 1: drives the AGU `controlIFFT`.

## Operation
- States and transitions:
  - IDLE → ARM on `start`.
  - ARM → RUN after 1 cycle.
  - RUN → DRAIN after the last butterfly slot.
  - DRAIN → FINISH after DRAIN_CYCLES.
  - FINISH → IDLE after 1 cycle.
- IDLE: `agu_reset`=1, `agu_mode`=`AGU_MODE_IDLE`, `agu_oe`=0. `start` while not IDLE is ignored.
- ARM: `agu_reset`=1 and `agu_ifft` is loaded from `ifft_req`. Counters are cleared: phase=0, bf=0, stage=0.
- RUN:
  - Outputs: `agu_reset`=0, `agu_mode`=`AGU_MODE_BF_RAM`, `agu_oe`=1.
  - `agu_start`=1 only in the first RUN cycle.
  - A 3-bit phase counter increments every cycle.
  - When phase wraps 7→0, `bf_index` increments.
  - When `bf_index` wraps from N/2-1 to 0, `stage` increments and `stage_done` pulses.
  - The last slot is stage=LOG_N-1, bf=N/2-1, phase=7.
- DRAIN: mode remains BF_RAM and `agu_oe`=1 so pending writes complete. `stage`/`bf_index` hold their final values. A drain counter runs.
- FINISH: `done`=1, `agu_oe`=0, `agu_reset`=1.
- `abort` in ARM, RUN or DRAIN goes to IDLE in the next cycle with no `done`. The AGU is held in reset from that cycle on.
- `abort` and `start` in the same IDLE cycle: `start` wins.
- `abort` in FINISH is ignored.
- Stage counter width clog2(LOG_N). The terminal compare is exact (LOG_N-1), never overflow-based.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `stage_done`=0, `stage`=0, `bf_index`=0, `agu_reset`=1, `agu_start`=0, `agu_mode`=`AGU_MODE_IDLE`, `agu_oe`=0, `agu_ifft`=0.
- Reference cycle: `start` high at cycle t.
  - ARM at t+1.
  - RUN spans t+2 … t+1+LOG_N·(N/2)·BF_CYCLES; `agu_start` is high at t+2 only.
  - DRAIN follows for DRAIN_CYCLES.
  - `done` is high at t+2+LOG_N·(N/2)·8+DRAIN_CYCLES.
  - `busy` falls the cycle after `done`.
- `stage_done` is high in the cycle after each stage's final phase-7 cycle. The final stage's pulse coincides with the first DRAIN cycle.
- `reset` mid-pass: all state returns to reset values next edge. No `done`.

## Configuration
- `FFT_SEQ_IFFT_EN` defined: `agu_ifft` is latched from `ifft_req` in ARM and held until the next ARM.
- Undefined: the `ifft_req` input still exists but is ignored, and `agu_ifft` is constant 0 (forward FFT only).

## Structure
- Shared package/defines (`00defines.v`): `AGU_MODE_WIDTH`, `AGU_MODE_BF_RAM`, `AGU_MODE_IDLE`, `LOG_N`, `NO_OF_POINTS`, and the state encodings `SEQ_IDLE`…`SEQ_FINISH`.
- One natural sub-module, `fft_seq_counter`: the cascaded phase/bf/stage counter with wrap pulses and a terminal flag.
- The FSM stays in the top.

## Test plan
- LOG_N=3, `start` pulse at cycle 10:
  - `agu_start` high only at cycle 12.
  - `stage_done` at cycles 44, 76 and 108.
  - `done` at cycle 116; `busy` low at 117.
- `start` held high throughout the pass: exactly one pass runs. A second pass begins at the ARM that follows `done`.
- `abort` at the RUN cycle with stage=1, bf=2:
  - Next cycle: IDLE, `agu_reset`=1, `agu_oe`=0.
  - No `done` pulse is produced.
- `reset` asserted in DRAIN: all outputs equal their reset values after the edge, and `done` never fires.
- `FFT_SEQ_IFFT_EN` defined, `ifft_req`=1 at `start`, then `ifft_req`=0 mid-pass: `agu_ifft` stays 1 through FINISH. Undefined: `agu_ifft`=0 always.
- `start` and `abort` together in IDLE: enters ARM, and a full pass completes.
